// File: rtl/eth_fcs_check.sv
// eth_fcs_check: Ethernet FCS (CRC-32) receive checker.
// Folds every received byte into a reflected CRC-32 register and compares the
// register with the fixed residue 0xDEBB20E3 after the final FCS byte. It also
// reports the frame length, length errors and PHY errors for each frame.
// Optional feature: define ETH_FCS_STRIP_EN to build a 4-byte delay path that
// re-emits each frame with its FCS removed on out_data/out_valid/out_last.
// When the macro is undefined, the out_* ports are tied to zero.
module eth_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        data_last,
  input  logic        rx_er,
  output logic        done,
  output logic        crc_ok,
  output logic        len_err,
  output logic        phy_err,
  output logic [11:0] frame_len,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [11:0] CNT_MAX     = 12'hFFF;

  // Fold one byte into the reflected CRC register, LSB first, with no final XOR.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc_in, input logic [7:0] byte_in);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ byte_in[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t      state_q;
  logic [31:0] crc_q, crc_d, crc_base_s;
  logic [11:0] cnt_q, cnt_d, cnt_base_s;
  logic        phy_q, phy_d, phy_base_s;
  logic        len_bad_s;
  logic [11:0] flen_s;

  // The first byte of a frame starts from fresh CRC, count and error state.
  // Later bytes continue from the accumulated frame state.
  always_comb begin
    crc_base_s = CRC_INIT;
    cnt_base_s = 12'd0;
    phy_base_s = 1'b0;
    case (state_q)
      IDLE: begin
        crc_base_s = CRC_INIT;
        cnt_base_s = 12'd0;
        phy_base_s = 1'b0;
      end
      RUN: begin
        crc_base_s = crc_q;
        cnt_base_s = cnt_q;
        phy_base_s = phy_q;
      end
      default: begin
        crc_base_s = CRC_INIT;
        cnt_base_s = 12'd0;
        phy_base_s = 1'b0;
      end
    endcase
    crc_d     = crc_fold(crc_base_s, data);
    cnt_d     = (cnt_base_s == CNT_MAX) ? CNT_MAX : cnt_base_s + 12'd1;
    phy_d     = phy_base_s | rx_er;
    len_bad_s = (cnt_d == CNT_MAX) || ({20'd0, cnt_d} < MIN_LEN) || ({20'd0, cnt_d} > MAX_LEN);
    flen_s    = (cnt_d > 12'd4) ? (cnt_d - 12'd4) : 12'd0;
  end

  // Frame state machine. It accumulates state on valid bytes; stall cycles
  // leave it unchanged. On data_last it publishes the frame status and
  // pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= CRC_INIT;
      cnt_q     <= 12'd0;
      phy_q     <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      len_err   <= 1'b0;
      phy_err   <= 1'b0;
      frame_len <= 12'd0;
    end else begin
      done <= 1'b0;
      if (data_valid) begin
        crc_q <= crc_d;
        cnt_q <= cnt_d;
        phy_q <= phy_d;
        if (data_last) begin
          state_q   <= IDLE;
          done      <= 1'b1;
          crc_ok    <= (crc_d == CRC_RESIDUE);
          len_err   <= len_bad_s;
          phy_err   <= phy_d;
          frame_len <= flen_s;
        end else begin
          state_q <= RUN;
        end
      end
    end
  end

`ifdef ETH_FCS_STRIP_EN
  logic [3:0][7:0] sbuf_q;
  logic [2:0]      fill_q, fill_base_s, fill_d;

  // The buffer counts as empty at the start of each frame, which flushes any
  // bytes left over from the previous frame.
  always_comb begin
    if (state_q == IDLE) begin
      fill_base_s = 3'd0;
    end else begin
      fill_base_s = fill_q;
    end
    fill_d = (fill_base_s == 3'd4) ? 3'd4 : fill_base_s + 3'd1;
  end

  // The 4-deep delay line emits the oldest byte only once four newer bytes
  // follow it, so the four FCS bytes are never emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf_q    <= '0;
      fill_q    <= 3'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
      if (data_valid) begin
        sbuf_q <= {sbuf_q[2:0], data};
        fill_q <= fill_d;
        if (fill_base_s == 3'd4) begin
          out_valid <= 1'b1;
          out_data  <= sbuf_q[3];
          out_last  <= data_last;
        end
      end
    end
  end
`else
  assign out_data  = 8'h00;
  assign out_valid = 1'b0;
  assign out_last  = 1'b0;
`endif

endmodule

// File: tb/tb_eth_fcs_check.sv
// tb_eth_fcs_check: directed, table-driven bench for eth_fcs_check.
module tb_eth_fcs_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_last = 1'b0;
  logic        rx_er = 1'b0;
  logic        done, crc_ok, len_err, phy_err, out_valid, out_last;
  logic [11:0] frame_len;
  logic [7:0]  out_data;

  eth_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .data_last(data_last), .rx_er(rx_er), .done(done), .crc_ok(crc_ok),
    .len_err(len_err), .phy_err(phy_err), .frame_len(frame_len),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [7:0]  last_b;
    int          er_pos;
    logic        exp_ok;
    logic        exp_len_err;
    logic        exp_phy;
    logic [11:0] exp_flen;
  } vec_t;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         cyc = 0;
  int         done_cyc[$];
  logic       done_ok[$];
  logic [7:0] od_q[$];
  logic       ol_q[$];
  logic [7:0] ref_b [13];
  logic [7:0] zf [64];
  vec_t       vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic log_cycle();
    cyc++;
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_ok.push_back(crc_ok);
    end
    if (out_valid === 1'b1) begin
      od_q.push_back(out_data);
      ol_q.push_back(out_last);
    end
  endtask

  task automatic clear_logs();
    done_cyc.delete();
    done_ok.delete();
    od_q.delete();
    ol_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic er);
    data = d;
    data_valid = 1'b1;
    data_last = last;
    rx_er = er;
    @(posedge clk);
    #1;
    log_cycle();
    data_valid = 1'b0;
    data_last = 1'b0;
    rx_er = 1'b0;
  endtask

  // Stall cycle driving junk on qualified inputs while data_valid is low.
  task automatic stall();
    data = 8'hFF;
    data_valid = 1'b0;
    data_last = 1'b1;
    rx_er = 1'b1;
    @(posedge clk);
    #1;
    log_cycle();
    data_last = 1'b0;
    rx_er = 1'b0;
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      log_cycle();
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic check_status(input string tag, input logic ok, input logic le,
                              input logic pe, input logic [11:0] fl);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_crc_ok"}, {31'd0, crc_ok}, {31'd0, ok});
    check({tag, "_len_err"}, {31'd0, len_err}, {31'd0, le});
    check({tag, "_phy_err"}, {31'd0, phy_err}, {31'd0, pe});
    check({tag, "_frame_len"}, {20'd0, frame_len}, {20'd0, fl});
  endtask

  initial begin
    logic [31:0] c;
    logic [7:0]  b;
    int          exp_out;
    int          totals [4];

    ref_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
    vecs[0] = '{13, 8'hCB, -1, 1'b1, 1'b1, 1'b0, 12'd9};
    vecs[1] = '{13, 8'hCA, -1, 1'b0, 1'b1, 1'b0, 12'd9};
    vecs[2] = '{13, 8'hCB,  4, 1'b1, 1'b1, 1'b1, 12'd9};
    vecs[3] = '{13, 8'hCB, 12, 1'b1, 1'b1, 1'b1, 12'd9};
    vecs[4] = '{1,  8'h31,  0, 1'b0, 1'b1, 1'b1, 12'd0};
    vecs[5] = '{5,  8'h35, -1, 1'b0, 1'b1, 1'b0, 12'd1};
    vecs[6] = '{4,  8'h34, -1, 1'b0, 1'b1, 1'b0, 12'd0};

    // Reset state, checked while rst_n is held low.
    #1;
    check("reset_outputs", {5'd0, done, crc_ok, len_err, phy_err, frame_len, out_data,
                            out_valid, out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      idle(2);
      clear_logs();
      for (int k = 0; k < vecs[v].n; k++) begin
        b = (k == vecs[v].n - 1) ? vecs[v].last_b : ref_b[k];
        send(b, (k == vecs[v].n - 1), (k == vecs[v].er_pos));
      end
      check_status($sformatf("vec%0d", v), vecs[v].exp_ok, vecs[v].exp_len_err,
                   vecs[v].exp_phy, vecs[v].exp_flen);
      check($sformatf("vec%0d_done_count", v), done_cyc.size(), 32'd1);
      idle(1);
      check($sformatf("vec%0d_done_pulse", v), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_held_len", v), {20'd0, frame_len}, {20'd0, vecs[v].exp_flen});
`ifdef ETH_FCS_STRIP_EN
      exp_out = (vecs[v].n > 4) ? vecs[v].n - 4 : 0;
`else
      exp_out = 0;
`endif
      check($sformatf("vec%0d_out_count", v), od_q.size(), exp_out);
      for (int i = 0; i < od_q.size() && i < exp_out; i++) begin
        check($sformatf("vec%0d_out_data%0d", v, i), {24'd0, od_q[i]}, {24'd0, ref_b[i]});
        check($sformatf("vec%0d_out_last%0d", v, i), {31'd0, ol_q[i]}, {31'd0, (i == exp_out - 1)});
      end
    end

    // 64-byte zero frame with its FCS, first stalled every other cycle, then unstalled.
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 60; k++) begin
      zf[k] = 8'h00;
      c = crc_step(c, 8'h00);
    end
    c = ~c;
    zf[60] = c[7:0];
    zf[61] = c[15:8];
    zf[62] = c[23:16];
    zf[63] = c[31:24];
    for (int pass = 0; pass < 2; pass++) begin
      idle(2);
      clear_logs();
      for (int k = 0; k < 64; k++) begin
        send(zf[k], (k == 63), 1'b0);
        if (pass == 0 && k != 63) stall();
      end
      check_status($sformatf("zero%0d", pass), 1'b1, 1'b0, 1'b0, 12'd60);
      check($sformatf("zero%0d_done_count", pass), done_cyc.size(), 32'd1);
    end

    // Length boundaries and counter saturation.
    totals = '{63, 1518, 1519, 4100};
    for (int t = 0; t < 4; t++) begin
      idle(1);
      for (int k = 0; k < totals[t]; k++) send(8'h00, (k == totals[t] - 1), 1'b0);
      check($sformatf("len%0d_len_err", totals[t]), {31'd0, len_err},
            {31'd0, (totals[t] < 64 || totals[t] > 1518)});
      check($sformatf("len%0d_frame_len", totals[t]), {20'd0, frame_len},
            (totals[t] > 4095) ? 32'd4091 : totals[t] - 4);
    end

    // Two good frames back-to-back with no idle gap.
    idle(2);
    clear_logs();
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 13; k++) send(ref_b[k], (k == 12), 1'b0);
    end
    idle(1);
    check("b2b_done_count", done_cyc.size(), 32'd2);
    if (done_cyc.size() == 2) begin
      check("b2b_spacing", done_cyc[1] - done_cyc[0], 32'd13);
      check("b2b_crc_ok0", {31'd0, done_ok[0]}, 32'd1);
      check("b2b_crc_ok1", {31'd0, done_ok[1]}, 32'd1);
    end

    // PHY error frame, then a reset in the middle of the next frame.
    idle(1);
    for (int k = 0; k < 13; k++) send(ref_b[k], (k == 12), (k == 4));
    check("er_phy_err", {31'd0, phy_err}, 32'd1);
    check("er_crc_ok", {31'd0, crc_ok}, 32'd1);
    for (int k = 0; k < 6; k++) send(ref_b[k], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {5'd0, done, crc_ok, len_err, phy_err, frame_len, out_data,
                               out_valid, out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    idle(3);
    check("midreset_no_done", done_cyc.size(), 32'd0);
    for (int k = 0; k < 13; k++) send(ref_b[k], (k == 12), 1'b0);
    check_status("post_reset", 1'b1, 1'b1, 1'b0, 12'd9);
    check("post_reset_done_count", done_cyc.size(), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
